// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: single-outstanding req/ack bus master with byte lanes and load extension.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_i,
    input  logic        mem_w_i,
    input  logic [2:0]  ubhw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  ubhw_q, ubhw_d;
    logic        lvld_q, lvld_d, err_q, err_d, mis_q, mis_d;

    logic        access, misal;
    logic [1:0]  lo_eff;
    logic [3:0]  be_eff;
    logic [31:0] wdata_rep, sh, ld_ext;

    assign access = (mem_r_i | mem_w_i) & ~flush_i;

    // Halfword drops addr[0], word drops addr[1:0]; codes other than B/H act as word.
    always_comb begin
        lo_eff    = 2'b00;
        be_eff    = 4'b1111;
        wdata_rep = wdata_i;
        case (ubhw_i[1:0])
            2'b00: begin
                lo_eff    = addr_i[1:0];
                be_eff    = 4'b0001 << addr_i[1:0];
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                lo_eff    = {addr_i[1], 1'b0};
                be_eff    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (ubhw_i[1:0] == 2'b00) ? 1'b0 :
                   (ubhw_i[1:0] == 2'b01) ? addr_i[0] : (addr_i[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign sh = bus_rdata_i >> {lo_q, 3'b000};

    always_comb begin
        case (ubhw_q[1:0])
            2'b00:   ld_ext = ubhw_q[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ld_ext = ubhw_q[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_ext = sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        ubhw_d  = ubhw_q;
        ldata_d = ldata_q;
        lvld_d  = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_o = 1'b1;
                    if (misal) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_w_i;
                        addr_d  = {addr_i[31:2], 2'b00};
                        be_d    = be_eff;
                        wdata_d = wdata_rep;
                        lo_d    = lo_eff;
                        ubhw_d  = ubhw_i;
                        cnt_d   = 32'd0;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        ldata_d = ld_ext;
                        lvld_d  = 1'b1;
                    end
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    ldata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            lo_q    <= 2'd0;
            ubhw_q  <= 3'd0;
            ldata_q <= 32'd0;
            lvld_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            ubhw_q  <= ubhw_d;
            ldata_q <= ldata_d;
            lvld_q  <= lvld_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign bus_req_o    = req_q;
    assign bus_we_o     = we_q;
    assign bus_addr_o   = addr_q;
    assign bus_be_o     = be_q;
    assign bus_wdata_o  = wdata_q;
    assign load_data_o  = ldata_q;
    assign load_valid_o = lvld_q;
    assign bus_err_o    = err_q;
    assign misalign_o   = mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus per-cycle compare and literal pins.
module tb_mem_access_unit;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_i, mem_w_i, flush_i, bus_ack_i;
    logic [2:0]  ubhw_i;
    logic [31:0] addr_i, wdata_i, bus_rdata_i;
    logic        bus_req_o, bus_we_o, load_valid_o, stall_o, bus_err_o, misalign_o;
    logic [31:0] bus_addr_o, bus_wdata_o, load_data_o;
    logic [3:0]  bus_be_o;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_r_i(mem_r_i), .mem_w_i(mem_w_i), .ubhw_i(ubhw_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic        cmp_en = 1'b0;
    logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_lvld = 0, exp_err = 0, exp_mis = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_ldata = 0;
    logic [3:0]  exp_be = 0;
    int          req_cycles, stall_cycles, mis_seen;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Width code -> access size in bytes; codes other than B/H are words.
    function automatic int m_size(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
        int n = m_size(f);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
        int n = m_size(f);
        return 4'(((1 << n) - 1) << m_off(f, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
        int n = m_size(f);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int n = m_size(f);
        logic [31:0] v = rd >> (8 * m_off(f, a));
        if (n == 4) return v;
        v = v & ((32'd1 << (8 * n)) - 32'd1);
        if (!f[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic m_misal(input logic [2:0] f, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return m_off(f, a) != int'(a[1:0]);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
            check("bus_req_o", {31'd0, bus_req_o}, {31'd0, exp_req});
            check("load_valid_o", {31'd0, load_valid_o}, {31'd0, exp_lvld});
            check("bus_err_o", {31'd0, bus_err_o}, {31'd0, exp_err});
            check("misalign_o", {31'd0, misalign_o}, {31'd0, exp_mis});
            check("load_data_o", load_data_o, exp_ldata);
            if (exp_req) begin
                check("bus_addr_o", bus_addr_o, exp_addr);
                check("bus_be_o", {28'd0, bus_be_o}, {28'd0, exp_be});
                check("bus_we_o", {31'd0, bus_we_o}, {31'd0, exp_we});
                check("bus_wdata_o", bus_wdata_o, exp_wdata);
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        if (stall_o) stall_cycles++;
        if (bus_req_o) req_cycles++;
        if (misalign_o) mis_seen++;
    endtask

    task automatic pulses_off();
        exp_lvld = 0;
        exp_err  = 0;
        exp_mis  = 0;
    endtask

    // One access from IDLE; ack_at = BUSY cycle carrying ack (0 = never).
    task automatic access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
        logic acked = 0;
        req_cycles = 0; stall_cycles = 0; mis_seen = 0;
        @(posedge clk); #1;
        mem_r_i = r; mem_w_i = w; ubhw_i = f; addr_i = a; wdata_i = wd; flush_i = 0;
        pulses_off();
        exp_stall = 1; exp_req = 0;
        sample();
        if (m_misal(f, a)) begin
            @(posedge clk); #1;
            mem_r_i = 0; mem_w_i = 0;
            exp_stall = 0; exp_mis = 1;
            sample();
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            mem_r_i = 0; mem_w_i = 0;
            exp_req = 1; exp_stall = 1; exp_we = w;
            exp_addr = a & 32'hFFFF_FFFC; exp_be = m_be(f, a); exp_wdata = m_wdata(f, wd);
            bus_ack_i = (k == ack_at);
            bus_rdata_i = (k == ack_at) ? rd : 32'h5A5A_A5A5;
            sample();
            if (k == 1) begin
                cap_addr = bus_addr_o; cap_be = bus_be_o; cap_wdata = bus_wdata_o; cap_we = bus_we_o;
            end
            if (k == ack_at) begin
                acked = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus_ack_i = 0;
        exp_req = 0; exp_stall = 0;
        if (acked) begin
            exp_lvld = !w;
            if (!w) exp_ldata = m_load(f, a, rd);
        end else begin
            exp_err = 1;
            exp_ldata = 0;
        end
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pulses_off();
            exp_stall = 0; exp_req = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_r_i = 0; mem_w_i = 0; ubhw_i = 0; addr_i = 0; wdata_i = 0;
        flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst bus_req_o", {31'd0, bus_req_o}, 0);
        check("rst bus_we_o", {31'd0, bus_we_o}, 0);
        check("rst bus_addr_o", bus_addr_o, 0);
        check("rst bus_be_o", {28'd0, bus_be_o}, 0);
        check("rst bus_wdata_o", bus_wdata_o, 0);
        check("rst load_data_o", load_data_o, 0);
        check("rst load_valid_o", {31'd0, load_valid_o}, 0);
        check("rst bus_err_o", {31'd0, bus_err_o}, 0);
        check("rst misalign_o", {31'd0, misalign_o}, 0);
        check("rst stall_o", {31'd0, stall_o}, 0);
        @(posedge clk); #1;
        rst = 0;
        cmp_en = 1;

        access(1, 0, 3'b010, 32'h1000, 0, 1, 32'hDEADBEEF);
        check("LW addr", cap_addr, 32'h1000);
        check("LW be", {28'd0, cap_be}, 32'hF);
        check("LW stall cycles", stall_cycles, 2);
        check("LW data", load_data_o, 32'hDEADBEEF);

        access(1, 0, 3'b000, 32'h1003, 0, 1, 32'h80123456);
        check("LB data", load_data_o, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h1003, 0, 1, 32'h80123456);
        check("LBU data", load_data_o, 32'h00000080);
        access(1, 0, 3'b101, 32'h1002, 0, 1, 32'h80123456);
        check("LHU data", load_data_o, 32'h00008012);
        access(1, 0, 3'b001, 32'h1000, 0, 1, 32'h0000_8001);
        check("LH data", load_data_o, 32'hFFFF8001);

        access(0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 1, 32'h0);
        check("SH we", {31'd0, cap_we}, 1);
        check("SH be", {28'd0, cap_be}, 32'hC);
        check("SH wdata", cap_wdata, 32'hABCDABCD);
        check("SH keeps load_data", load_data_o, 32'hFFFF8001);
        access(0, 1, 3'b000, 32'h2001, 32'h000000CD, 2, 32'h0);
        check("SB be", {28'd0, cap_be}, 32'h2);
        check("SB wdata", cap_wdata, 32'hCDCDCDCD);
        access(1, 1, 3'b010, 32'h2004, 32'h55667788, 1, 32'h0);
        check("R+W is store", {31'd0, cap_we}, 1);

        access(1, 0, 3'b010, 32'h1004, 0, 5, 32'h11223344);
        check("delay req cycles", req_cycles, 5);
        check("delay stall cycles", stall_cycles, 6);
        check("delay data", load_data_o, 32'h11223344);

        access(1, 0, 3'b010, 32'h1008, 0, 0, 32'h0);
        check("timeout req cycles", req_cycles, TO);
        check("timeout data", load_data_o, 32'h0);

        access(1, 0, 3'b010, 32'h1002, 0, 1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
        check("misal pulse", mis_seen, 1);
        check("misal no req", req_cycles, 0);
`else
        check("unaligned LW addr", cap_addr, 32'h1000);
        check("unaligned LW be", {28'd0, cap_be}, 32'hF);
        check("unaligned LW data", load_data_o, 32'hCAFEF00D);
`endif

        @(posedge clk); #1;
        pulses_off();
        mem_r_i = 1; flush_i = 1; ubhw_i = 3'b010; addr_i = 32'h1010;
        exp_stall = 0; exp_req = 0;
        @(negedge clk);
        check("flush stall", {31'd0, stall_o}, 0);
        @(posedge clk); #1;
        mem_r_i = 0; flush_i = 0;
        @(negedge clk);
        check("flush no req", {31'd0, bus_req_o}, 0);

        @(posedge clk); #1;
        mem_r_i = 1; ubhw_i = 3'b010; addr_i = 32'h3000; wdata_i = 0;
        exp_stall = 1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_r_i = 0;
        exp_req = 1; exp_addr = 32'h3000; exp_be = 4'hF; exp_we = 0; exp_wdata = 0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("rst drops req", {31'd0, bus_req_o}, 0);
        exp_req = 0; exp_stall = 0; exp_ldata = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);

        access(1, 0, 3'b000, 32'h1001, 0, 1, 32'h0000_7F00);
        check("post-reset LB", load_data_o, 32'h0000007F);
        idle(2);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
